// File: rtl/thor2024_mulu_unit_pkg.sv
// Thor2024pkg: shared types and constants for the unsigned-multiply unit
package Thor2024pkg;
  localparam int MULU_BPC = 2;
  localparam int ROB_TAGW = 5;
  typedef logic [ROB_TAGW-1:0] rob_tag_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mulu_state_t;
endpackage

// File: rtl/thor2024_mulu_step.sv
// thor2024_mulu_step: radix-4 partial product (0, a, 2a, 3a) shifted into the accumulator
module thor2024_mulu_step #(
  parameter int WID = 64,
  parameter int SW  = 7
) (
  input  logic [2*WID-1:0] i_acc,
  input  logic [WID-1:0]   i_a,
  input  logic [1:0]       i_bits,
  input  logic [SW-1:0]    i_shift,
  output logic [2*WID-1:0] o_acc
);
  logic [WID+1:0]   w_pp;
  logic [2*WID-1:0] w_ext;
  assign w_pp  = (i_bits[1] ? {1'b0, i_a, 1'b0} : '0) + (i_bits[0] ? {2'b0, i_a} : '0);
  assign w_ext = {{(WID-2){1'b0}}, w_pp};
  assign o_acc = i_acc + (w_ext << i_shift);
endmodule

// File: rtl/thor2024_mulu_unit.sv
// thor2024_mulu_unit: iterative radix-4 unsigned multiplier returning the low or high product half
module thor2024_mulu_unit
  import Thor2024pkg::*;
#(
  parameter int WID  = 64,
  parameter int BPC  = MULU_BPC,
  parameter int TAGW = ROB_TAGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            mulu,
  input  logic            op_hi,
  input  logic            op_imm,
  input  logic [WID-1:0]  a,
  input  logic [WID-1:0]  b,
  input  logic [WID-1:0]  imm,
  input  logic [TAGW-1:0] tag,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [WID-1:0]  res,
  output logic [TAGW-1:0] res_tag
);
  localparam int SW = $clog2(2*WID);
  localparam int CW = $clog2(WID/BPC) + 1;
  mulu_state_t      r_state;
  logic [2*WID-1:0] r_acc;
  logic [WID-1:0]   r_a;
  logic [WID-1:0]   r_b;
  logic             r_hi;
  logic [TAGW-1:0]  r_tag;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_shift;
  logic [2*WID-1:0] w_acc;
  thor2024_mulu_step #(.WID(WID), .SW(SW)) u_step (
    .i_acc  (r_acc),
    .i_a    (r_a),
    .i_bits (r_b[1:0]),
    .i_shift(r_shift),
    .o_acc  (w_acc)
  );
  assign ld_ready  = r_state == IDLE;
  assign res_valid = r_state == DONE;
  assign res       = r_hi ? r_acc[2*WID-1:WID] : r_acc[WID-1:0];
  assign res_tag   = r_tag;
  // FSM: accept in IDLE, retire two multiplier bits per BUSY edge, hold result in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= 1'b0;
      r_tag   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (flush) begin
      r_state <= IDLE;
    end else if (r_state == IDLE && ld_valid && mulu) begin
      r_state <= BUSY;
      r_acc   <= '0;
      r_a     <= a;
      r_b     <= op_imm ? imm : b;
      r_hi    <= op_hi;
      r_tag   <= tag;
      r_cnt   <= CW'(WID/BPC);
      r_shift <= '0;
    end else if (r_state == BUSY) begin
      r_acc   <= w_acc;
      r_b     <= r_b >> BPC;
      r_shift <= r_shift + SW'(BPC);
      r_cnt   <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_state <= DONE;
    end else if (r_state == DONE && res_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_thor2024_mulu_unit.sv
// tb_thor2024_mulu_unit: directed and random checks of the unsigned-multiply unit against a 128-bit product model
module tb_thor2024_mulu_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        mulu = 1'b0;
  logic        op_hi = 1'b0;
  logic        op_imm = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [63:0] imm = '0;
  logic [4:0]  tag = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [63:0] res;
  logic [4:0]  res_tag;
  int checks = 0;
  int errors = 0;
  thor2024_mulu_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .mulu(mulu), .op_hi(op_hi), .op_imm(op_imm), .a(a), .b(b), .imm(imm), .tag(tag),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .res_tag(res_tag)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [63:0] ma, input logic [63:0] mm, input logic hi);
    logic [127:0] p;
    p = {64'b0, ma} * {64'b0, mm};
    return hi ? p[127:64] : p[63:0];
  endfunction
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  task automatic do_op(input logic [63:0] ia, input logic [63:0] ib, input logic [63:0] iimm,
                       input logic iimmsel, input logic ihi, input logic [4:0] itag, input int hold);
    int n;
    logic [63:0] exp_res;
    exp_res = model(ia, iimmsel ? iimm : ib, ihi);
    @(negedge clk);
    chk("ld_ready_before_accept", 64'(ld_ready), 64'd1);
    ld_valid = 1'b1; mulu = 1'b1; a = ia; b = ib; imm = iimm; op_imm = iimmsel; op_hi = ihi; tag = itag;
    res_ready = (hold == 0);
    @(posedge clk);
    #1;
    ld_valid = 1'b0; a = rnd64(); b = rnd64(); imm = rnd64(); tag = 5'($urandom);
    n = 0;
    while (n < 40) begin
      n++;
      @(posedge clk);
      #1;
      if (res_valid) break;
    end
    chk("latency", 64'(n), 64'd32);
    chk("res", res, exp_res);
    chk("res_tag", 64'(res_tag), 64'(itag));
    for (int i = 0; i < hold; i++) begin
      ld_valid = 1'b1; mulu = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_res", res, exp_res);
      chk("hold_tag", 64'(res_tag), 64'(itag));
      chk("hold_no_ready", 64'(ld_ready), 64'd0);
    end
    ld_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ld_ready_after_consume", 64'(ld_ready), 64'd1);
    chk("res_valid_after_consume", 64'(res_valid), 64'd0);
  endtask
  task automatic no_valid_for(input string name, input int cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ld_ready", 64'(ld_ready), 64'd1);
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk("reset_res", res, 64'd0);
    chk("reset_res_tag", 64'(res_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(64'd3, 64'd5, 64'd0, 1'b0, 1'b0, 5'd7, 0);
    do_op('1, '1, 64'd0, 1'b0, 1'b1, 5'd1, 0);
    do_op('1, '1, 64'd0, 1'b0, 1'b0, 5'd2, 0);
    do_op(64'h1_0000_0000, 64'hDEAD_BEEF_0BAD_F00D, 64'h10, 1'b1, 1'b0, 5'd3, 0);
    do_op(64'h1_0000_0000, 64'hDEAD_BEEF_0BAD_F00D, 64'h10, 1'b1, 1'b1, 5'd4, 0);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'd0, 1'b0, 1'b1, 5'd21, 10);
    do_op(64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 5'd9, 0);
    @(negedge clk);
    ld_valid = 1'b1; mulu = 1'b0; a = 64'd6; b = 64'd7;
    @(posedge clk);
    #1;
    chk("mulu0_ld_ready", 64'(ld_ready), 64'd1);
    no_valid_for("mulu0_ignored", 36);
    ld_valid = 1'b0;
    @(negedge clk);
    ld_valid = 1'b1; mulu = 1'b1; a = 64'd9; b = 64'd9; flush = 1'b1;
    @(posedge clk);
    #1;
    ld_valid = 1'b0; flush = 1'b0;
    chk("flush_ld_ld_ready", 64'(ld_ready), 64'd1);
    no_valid_for("flush_ld_no_result", 36);
    @(negedge clk);
    ld_valid = 1'b1; mulu = 1'b1; a = 64'd11; b = 64'd13; tag = 5'd5;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_before_flush", 64'(ld_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy_idle", 64'(ld_ready), 64'd1);
    no_valid_for("flush_busy_no_result", 36);
    do_op(64'd2, 64'd2, 64'd0, 1'b0, 1'b0, 5'd12, 0);
    @(negedge clk);
    ld_valid = 1'b1; mulu = 1'b1; a = '1; b = '1; op_hi = 1'b1; op_imm = 1'b0; tag = 5'd30;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("async_rst_res_valid", 64'(res_valid), 64'd0);
    chk("async_rst_res", res, 64'd0);
    chk("async_rst_res_tag", 64'(res_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_valid_for("after_reset_no_result", 36);
    for (int k = 0; k < 20; k++)
      do_op(rnd64(), rnd64(), rnd64(), 1'($urandom), 1'($urandom), 5'($urandom), (k % 5 == 0) ? 3 : 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
